// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// Module     : alu_arbiter
// Description: Two-requester front end for one shared combinational ALU.
//              One operation is in flight at a time (IDLE -> EXEC -> RESP).
//              Define ALU_ARB_RR_EN for round-robin grant; the default is
//              fixed priority with req0 winning.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_fun,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_fun,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  alu_fun,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  input  logic [31:0] alu_result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_fun;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic        r_owner;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_idle;
  logic        w_owner_ready;

  assign w_idle = (r_state == S_IDLE);

`ifdef ALU_ARB_RR_EN
  // r_last is 1 when req1 was granted last; reset value makes req0 win first
  logic r_last;

  always_comb begin
    w_grant0 = req0_valid & (~req1_valid | r_last);
    w_grant1 = req1_valid & (~req0_valid | ~r_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant1;
    end
  end
`else
  always_comb begin
    w_grant0 = req0_valid;
    w_grant1 = req1_valid & ~req0_valid;
  end
`endif

  assign req0_ready    = w_idle & w_grant0;
  assign req1_ready    = w_idle & w_grant1;
  assign w_accept      = req0_ready | req1_ready;
  assign w_owner_ready = r_owner ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_fun    <= 4'b0000;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_result <= 32'd0;
      r_owner  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_fun   <= req1_ready ? req1_fun : req0_fun;
            r_a     <= req1_ready ? req1_a   : req0_a;
            r_b     <= req1_ready ? req1_b   : req0_b;
            r_owner <= req1_ready;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= alu_result;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          if (w_owner_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The ALU only sees operands while an operation is executing
  assign alu_fun    = (r_state == S_EXEC) ? r_fun : 4'b0000;
  assign alu_srcA   = (r_state == S_EXEC) ? r_a   : 32'd0;
  assign alu_srcB   = (r_state == S_EXEC) ? r_b   : 32'd0;

  assign rsp0_valid = (r_state == S_RESP) & ~r_owner;
  assign rsp1_valid = (r_state == S_RESP) &  r_owner;
  assign rsp_result = r_result;

endmodule

`default_nettype wire
